gmem_blitter: RTL
=================

# gmem_blitter

Pixel writer for the 1-bit, 160x120, two-page graphics memory that the VGA display path scans out. Accepts rectangle draw commands (fill or 16-pixel-wide sprite rows from a sprite ROM), clips them to the screen, and issues one framebuffer write per cycle on the GRAM write port. It sits between the game CPU's MMIO command register and the framebuffer GRAM's write side.

## Interface
- FB_WIDTH, 160, framebuffer columns
- FB_HEIGHT, 120, framebuffer rows
- PAGE_SIZE, 19200, pixels per page (FB_WIDTH*FB_HEIGHT)
- ADDR_WIDTH, 17, framebuffer address width ($clog2(PAGE_SIZE)+2)
- SPR_ADDR_WIDTH, 10, sprite ROM address width
- clk  in  1  system clock; single clock domain
- reset  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  block idle, command accepted when cmd_valid && cmd_ready
- cmd_x  in  8  left column of rectangle
- cmd_y  in  7  top row of rectangle
- cmd_w  in  4  width minus 1 (1..16 columns)
- cmd_h  in  4  height minus 1 (1..16 rows)
- cmd_page  in  1  target page
- cmd_mode  in  2  0 CLEAR, 1 SET, 2 SPRITE_TRANSPARENT, 3 SPRITE_OPAQUE
- cmd_src  in  SPR_ADDR_WIDTH  sprite base; row r at cmd_src + r
- spr_addr  out  SPR_ADDR_WIDTH  sprite ROM address
- spr_data  in  16  sprite row, bit 15 = leftmost column, valid one cycle after spr_addr
- stall  in  1  hold off writes (e.g. outside vblank)
- fb_wEn  out  1  framebuffer write enable
- fb_addr  out  ADDR_WIDTH  x + 160*y + page*PAGE_SIZE
- fb_data  out  1  pixel value
- busy  out  1  high from acceptance until done
- done  out  1  one-cycle pulse after last pixel

## Operation
- States: IDLE, FETCH, WAIT, DRAW, DONE.
- IDLE: cmd_ready=1. On accept, latch all cmd_* fields, zero row/col counters. Go to FETCH for sprite modes, DRAW for fill modes.
- FETCH: drive spr_addr = src + row. Go to WAIT.
- WAIT: latch spr_data into the row shift register. Go to DRAW.
- DRAW: one column per cycle unless stall=1, in which case counters and state hold and fb_wEn=0.
  - Pixel value: CLEAR→0, SET→1, sprites→row bit (15-col).
  - fb_wEn=1 except when clipped (x+col ≥ 160 or y+row ≥ 120) or in SPRITE_TRANSPARENT with bit=0.
  - Clipped or transparent pixels still consume one cycle.
  - After col==w: if row==h go to DONE, else row++, col=0, and go to FETCH (sprite) or stay in DRAW (fill).
- DONE: done=1 and busy=1 for one cycle, then IDLE.
- Arithmetic: x+col computed 9 bits wide, y+row 8 bits wide, with no wrap. Clipped pixels never alias onto another row or page.
- cmd_* changes while busy are ignored. No command queueing.

## Timing
- Reset (reset=0, async): state IDLE. cmd_ready=1. busy, done, fb_wEn, fb_data, fb_addr and spr_addr all 0. Counters cleared.
- Reset asserted mid-command aborts it. No writes occur after assertion, and no done pulse is produced.
- All outputs are registered from state and counters. Accept at cycle 0 gives:
  - Fill: first write in cycle 1.
  - Sprite: spr_addr in cycle 1, data latched in cycle 2, first write in cycle 3.
- Per-row cost: (w+1) cycles for fill, (w+1)+2 cycles for sprite. Each stall cycle adds one cycle.
- done is asserted in the cycle after the last DRAW cycle. cmd_ready returns the following cycle.
- stall has no effect in FETCH, WAIT or DONE.

## Structure
- Shared package gfx_pkg: FB_WIDTH, FB_HEIGHT, PAGE_SIZE, cmd_mode encodings, blitter state enum. The display path uses the same constants.
- One sub-module, gmem_addr_calc: combinational (x9, y8, page) → (addr, clip). Reused later by any other framebuffer writer.

## Test plan
- Reset, then SET at (0,0), w=3, h=1, page 0, accepted cycle 0 → writes fb_data=1 at addrs 0,1,2,3 (cycles 1-4) and 160-163 (cycles 5-8); done cycle 9; cmd_ready cycle 10.
- SPRITE_TRANSPARENT at (10,5), w=15, h=0, page 1, spr_data=16'hA000 → spr_addr=src cycle 1; exactly two writes: addr 19200+810 (cycle 3) and 19200+812 (cycle 5), both data=1; done cycle 19.
- SPRITE_OPAQUE at (158,119), w=3, h=1, spr_data=16'hFFFF → only (158,119) and (159,119) written (addrs 19198, 19199); row 120 fully clipped; done after 2*(4+2)=12 cycles.
- CLEAR at (0,0), w=0, h=0 with stall=1 held cycles 1-3 → no write cycles 1-3; write addr 0, data 0 in cycle 4; done cycle 5.
- Assert reset during the third write of a 16x16 SET → outputs reset values immediately, no further fb_wEn, no done; the next command executes normally.
- cmd_valid held high with changing fields while busy → only the first command executes; cmd_ready stays 0 until after done.

Source files
------------

// File: rtl/gfx_pkg.sv
// gfx_pkg: framebuffer geometry, blitter command modes and blitter FSM states shared by the display path
package gfx_pkg;
  localparam int FB_WIDTH = 160;
  localparam int FB_HEIGHT = 120;
  localparam int PAGE_SIZE = FB_WIDTH * FB_HEIGHT;
  localparam int ADDR_WIDTH = $clog2(PAGE_SIZE) + 2;
  localparam int SPR_ADDR_WIDTH = 10;
  typedef enum logic [1:0] {MODE_CLEAR, MODE_SET, MODE_SPR_TRANS, MODE_SPR_OPAQUE} mode_e;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_DRAW, S_DONE} state_e;
endpackage

// File: rtl/gmem_addr_calc.sv
// gmem_addr_calc: maps an unwrapped pixel coordinate to a framebuffer address and flags off-screen pixels
//   x     in  9-bit column, y in 8-bit row, page in page select
//   addr  out x + FB_WIDTH*y + page*PAGE_SIZE
//   clip  out coordinate lies outside the visible page
module gmem_addr_calc
  import gfx_pkg::*;
(
  input  logic [8:0]            x,
  input  logic [7:0]            y,
  input  logic                  page,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  clip
);
  always_comb begin
    clip = x >= 9'(FB_WIDTH) || y >= 8'(FB_HEIGHT);
    addr = ADDR_WIDTH'(x) + ADDR_WIDTH'(y) * ADDR_WIDTH'(FB_WIDTH) + (page ? ADDR_WIDTH'(PAGE_SIZE) : '0);
  end
endmodule

// File: rtl/gmem_blitter.sv
// gmem_blitter: clipped rectangle fill / sprite blitter writing one pixel per cycle into the 1-bit framebuffer
//   clk, reset (async, active low)
//   cmd_*      command handshake and fields (x, y, w-1, h-1, page, mode, sprite base)
//   spr_addr   sprite ROM address, spr_data returns one cycle later (bit 15 = leftmost)
//   stall      holds the draw counters and suppresses writes
//   fb_*       framebuffer write port; busy/done command status
module gmem_blitter
  import gfx_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [7:0]                cmd_x,
  input  logic [6:0]                cmd_y,
  input  logic [3:0]                cmd_w,
  input  logic [3:0]                cmd_h,
  input  logic                      cmd_page,
  input  logic [1:0]                cmd_mode,
  input  logic [SPR_ADDR_WIDTH-1:0] cmd_src,
  output logic [SPR_ADDR_WIDTH-1:0] spr_addr,
  input  logic [15:0]               spr_data,
  input  logic                      stall,
  output logic                      fb_wEn,
  output logic [ADDR_WIDTH-1:0]     fb_addr,
  output logic                      fb_data,
  output logic                      busy,
  output logic                      done
);
  state_e state, state_nx;
  mode_e mode;
  logic [7:0] x;
  logic [6:0] y;
  logic [3:0] w, h, row, col;
  logic page;
  logic [SPR_ADDR_WIDTH-1:0] src;
  logic [15:0] bits;
  logic [8:0] px;
  logic [7:0] py;
  logic [ADDR_WIDTH-1:0] addr;
  logic clip, bit_v, step, last_col, last_row;
  gmem_addr_calc u_addr (.x(px), .y(py), .page(page), .addr(addr), .clip(clip));
  always_comb begin
    px = {1'b0, x} + {5'b0, col};
    py = {1'b0, y} + {4'b0, row};
    bit_v = bits[~col];
    step = state == S_DRAW && !stall;
    last_col = col == w;
    last_row = row == h;
    state_nx = state;
    case (state)
      S_IDLE:  state_nx = cmd_valid ? (cmd_mode[1] ? S_FETCH : S_DRAW) : S_IDLE;
      S_FETCH: state_nx = S_WAIT;
      S_WAIT:  state_nx = S_DRAW;
      S_DRAW:  state_nx = step && last_col ? (last_row ? S_DONE : mode[1] ? S_FETCH : S_DRAW) : S_DRAW;
      default: state_nx = S_IDLE;
    endcase
    cmd_ready = state == S_IDLE;
    busy = !cmd_ready;
    done = state == S_DONE;
    spr_addr = state == S_FETCH ? src + SPR_ADDR_WIDTH'(row) : '0;
    fb_addr = state == S_DRAW ? addr : '0;
    fb_data = state == S_DRAW && (mode == MODE_SET || (mode[1] && bit_v));
    // clipped and transparent pixels still spend their cycle, they just don't write
    fb_wEn = step && !clip && !(mode == MODE_SPR_TRANS && !bit_v);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= S_IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      {x, y, w, h, row, col, page, src, bits} <= '0;
      mode <= MODE_CLEAR;
    end else if (state == S_IDLE && cmd_valid) begin
      {x, y, w, h, page, src} <= {cmd_x, cmd_y, cmd_w, cmd_h, cmd_page, cmd_src};
      mode <= mode_e'(cmd_mode);
      row <= '0;
      col <= '0;
    end else if (state == S_WAIT) bits <= spr_data;
    else if (step) begin
      col <= last_col ? '0 : col + 1'b1;
      row <= last_col ? row + 1'b1 : row;
    end
endmodule
